// File: rtl/dcache_wb_direct.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the
// pipeline MEM stage and a 128-bit block memory. Loads hit with zero latency;
// misses write back a dirty victim, fetch the new line and then replay the
// original access as a hit.

module dcache_wb_direct #(
    parameter int IDX_BITS = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [2:0]   cpu_funct3,
    input  logic [31:0]  cpu_address,
    input  logic [31:0]  cpu_writedata,
    output logic [31:0]  cpu_readdata,
    output logic         cpu_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int TAG_BITS = 28 - IDX_BITS;
    localparam int LINES    = 1 << IDX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, MEM_READ, UPDATE} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [127:0]        lines [LINES];
    logic [127:0]        fill;

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [3:0]          offset;
    logic                request;
    logic                hit;
    logic                load_hit;
    logic                store_hit;
    logic [127:0]        line;
    logic [127:0]        merged;
    logic [7:0]          byte_val;
    logic [15:0]         half_val;
    logic [31:0]         word_val;

    // Address decode, hit detection and stall generation
    always_comb begin
        idx       = cpu_address[3+IDX_BITS:4];
        tag       = cpu_address[31:4+IDX_BITS];
        offset    = cpu_address[3:0];
        request   = cpu_read ^ cpu_write;
        line      = lines[idx];
        hit       = valid[idx] && (tags[idx] == tag);
        load_hit  = cpu_read && !cpu_write && (state == IDLE) && hit;
        store_hit = cpu_write && !cpu_read && (state == IDLE) && hit;
        cpu_busywait = !reset && request && !((state == IDLE) && hit);
    end

    // Load path: pick the aligned byte/half/word and extend it
    always_comb begin
        byte_val     = line[{offset, 3'b000} +: 8];
        half_val     = line[{offset[3:1], 4'b0000} +: 16];
        word_val     = line[{offset[3:2], 5'b00000} +: 32];
        cpu_readdata = '0;
        if (load_hit) begin
            case (cpu_funct3)
                3'b000:  cpu_readdata = {{24{byte_val[7]}}, byte_val};
                3'b001:  cpu_readdata = {{16{half_val[15]}}, half_val};
                3'b010:  cpu_readdata = word_val;
                3'b100:  cpu_readdata = {24'h0, byte_val};
                3'b101:  cpu_readdata = {16'h0, half_val};
                default: cpu_readdata = '0;
            endcase
        end
    end

    // Store path: merge the store data into a copy of the selected line
    always_comb begin
        merged = line;
        case (cpu_funct3[1:0])
            2'b00:   merged[{offset, 3'b000} +: 8]        = cpu_writedata[7:0];
            2'b01:   merged[{offset[3:1], 4'b0000} +: 16] = cpu_writedata[15:0];
            default: merged[{offset[3:2], 5'b00000} +: 32] = cpu_writedata;
        endcase
    end

    // Miss-handling state machine with registered memory-side requests
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            valid         <= '0;
            dirty         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tags[idx], idx};
                            mem_writedata <= line;
                        end else begin
                            state       <= MEM_READ;
                            mem_read    <= 1'b1;
                            mem_address <= cpu_address[31:4];
                        end
                    end else if (store_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= MEM_READ;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= cpu_address[31:4];
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    state      <= IDLE;
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line data and tag storage, plus the fill buffer for the fetched line
    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            lines[idx] <= fill;
            tags[idx]  <= tag;
        end else if (store_hit) begin
            lines[idx] <= merged;
        end
        if ((state == MEM_READ) && !mem_busywait) begin
            fill <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_dcache_wb_direct.sv
// Self-checking bench for dcache_wb_direct: a flat byte-addressed golden
// memory plus a per-index residency model predict load data, stall length
// and memory traffic for directed and random accesses.

module tb_dcache_wb_direct;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [2:0]   cpu_funct3;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_writedata;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dcache_wb_direct dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_funct3    (cpu_funct3),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Deterministic initial memory contents, shared by backing store and golden model
    function automatic logic [7:0] init_byte(input int a);
        int v;
        v = (a * 167) ^ ((a >> 4) * 29) ^ 90;
        return v[7:0];
    endfunction

    function automatic logic [127:0] init_line(input int b);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = init_byte(b * 16 + k);
        return l;
    endfunction

    // Backing block memory: each request stays busy for 16 cycles
    logic [127:0] back_mem [0:255];
    logic [3:0]   cnt;
    logic         load_mem;

    assign mem_busywait = (mem_read || mem_write) && (cnt != 4'd15);
    assign mem_readdata = back_mem[mem_address[7:0]];

    always @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (mem_read || mem_write) cnt <= cnt + 4'd1;
        else cnt <= '0;
    end

    always @(posedge clock) begin
        if (load_mem) begin
            for (int b = 0; b < 256; b++) back_mem[b] <= init_line(b);
        end else if (mem_write && !mem_busywait) begin
            back_mem[mem_address[7:0]] <= mem_writedata;
        end
    end

    // Golden architectural memory and cache residency model
    logic [7:0] gold [0:4095];
    bit         m_valid [8];
    bit         m_dirty [8];
    int         m_tag   [8];

    function automatic logic [127:0] gold_line(input int b);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = gold[b * 16 + k];
        return l;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int a;
        a = int'(addr[11:0]);
        case (f3)
            3'b000: return {{24{gold[a][7]}}, gold[a]};
            3'b100: return {24'h0, gold[a]};
            3'b001: begin a = a & ~1; return {{16{gold[a+1][7]}}, gold[a+1], gold[a]}; end
            3'b101: begin a = a & ~1; return {16'h0, gold[a+1], gold[a]}; end
            3'b010: begin a = a & ~3; return {gold[a+3], gold[a+2], gold[a+1], gold[a]}; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        int a;
        a = int'(addr[11:0]);
        case (f3[1:0])
            2'b00: gold[a] = wd[7:0];
            2'b01: begin a = a & ~1; gold[a] = wd[7:0]; gold[a+1] = wd[15:8]; end
            default: begin
                a = a & ~3;
                gold[a] = wd[7:0]; gold[a+1] = wd[15:8];
                gold[a+2] = wd[23:16]; gold[a+3] = wd[31:24];
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Observations of one access, and the expected memory-side values
    int           obs_busy, obs_rd, obs_wr, obs_bad, obs_both;
    logic         obs_done;
    logic [31:0]  obs_rdata;
    logic [27:0]  exp_rd_addr, exp_wb_addr;
    logic [127:0] exp_wb_line;
    int           acc_num = 0;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clock);
        #1;
        cpu_read = rd; cpu_write = wr; cpu_funct3 = f3;
        cpu_address = addr; cpu_writedata = wdata;
        obs_busy = 0; obs_rd = 0; obs_wr = 0; obs_bad = 0; obs_both = 0;
        obs_done = 1'b0; obs_rdata = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (mem_read && mem_write) obs_both++;
            if (mem_read) begin
                obs_rd++;
                if (mem_address !== exp_rd_addr) obs_bad++;
            end
            if (mem_write) begin
                obs_wr++;
                if (mem_address !== exp_wb_addr || mem_writedata !== exp_wb_line) obs_bad++;
            end
            if (!cpu_busywait) begin
                obs_done  = 1'b1;
                obs_rdata = cpu_readdata;
                break;
            end
            obs_busy++;
            @(posedge clock);
        end
        checkOutput($sformatf("a%0d_done", acc_num), obs_done, 1);
        @(posedge clock);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int idx, tag, victim;
        bit hit, dirty_miss;
        logic [31:0] exp_data;
        idx = int'(addr[6:4]);
        tag = int'(addr[31:7]);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        dirty_miss = !hit && m_valid[idx] && m_dirty[idx];
        victim = m_tag[idx] * 8 + idx;
        exp_rd_addr = addr[31:4];
        exp_wb_addr = dirty_miss ? 28'(victim) : '0;
        exp_wb_line = dirty_miss ? gold_line(victim) : '0;
        exp_data = (rd && !wr) ? model_load(addr, f3) : 32'h0;
        acc_num++;
        applyStimulus(rd, wr, f3, addr, wdata);
        checkOutput($sformatf("a%0d_busy", acc_num), obs_busy, hit ? 0 : (dirty_miss ? 34 : 18));
        checkOutput($sformatf("a%0d_rdata", acc_num), obs_rdata, exp_data);
        checkOutput($sformatf("a%0d_rdcyc", acc_num), obs_rd, hit ? 0 : 16);
        checkOutput($sformatf("a%0d_wrcyc", acc_num), obs_wr, dirty_miss ? 16 : 0);
        checkOutput($sformatf("a%0d_memaddr", acc_num), obs_bad, 0);
        checkOutput($sformatf("a%0d_rdwr", acc_num), obs_both, 0);
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        if (wr && !rd) begin
            model_store(addr, f3, wdata);
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [2:0] load_f3 [5];
        logic       seen;
        load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int a = 0; a < 4096; a++) gold[a] = init_byte(a);
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end

        reset = 1'b1; load_mem = 1'b1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_funct3 = 3'b010;
        cpu_address = 32'h40; cpu_writedata = '0;
        @(posedge clock); @(posedge clock);
        #1 load_mem = 1'b0;
        @(negedge clock);
        checkOutput("rst_busywait", cpu_busywait, 0);
        checkOutput("rst_mem_read", mem_read, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_address", mem_address, 0);
        checkOutput("rst_mem_wdata", mem_writedata, 0);
        checkOutput("rst_readdata", cpu_readdata, 0);
        cpu_read = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] directed accesses");
        runAccess(1, 0, 3'b010, 32'h40, 0);
        checkOutput("lw40_busy18", obs_busy, 18);
        runAccess(0, 1, 3'b010, 32'h44, 32'hDEADBEEF);
        checkOutput("sw44_nostall", obs_busy, 0);
        runAccess(1, 0, 3'b010, 32'h44, 0);
        checkOutput("lw44", obs_rdata, 32'hDEADBEEF);
        runAccess(1, 0, 3'b000, 32'h47, 0);
        checkOutput("lb47", obs_rdata, 32'hFFFFFFDE);
        runAccess(1, 0, 3'b100, 32'h47, 0);
        checkOutput("lbu47", obs_rdata, 32'h000000DE);
        runAccess(1, 0, 3'b101, 32'h46, 0);
        checkOutput("lhu46", obs_rdata, 32'h0000DEAD);
        runAccess(0, 1, 3'b001, 32'h45, 32'h00001234);
        runAccess(1, 0, 3'b010, 32'h44, 0);
        checkOutput("lw44_merged", obs_rdata, 32'hDEAD1234);
        runAccess(1, 0, 3'b010, 32'hC4, 0);
        checkOutput("lwC4_busy34", obs_busy, 34);
        checkOutput("wb_mem_44", back_mem[4][63:32], 32'hDEAD1234);

        $display("[TB] simultaneous read and write");
        @(posedge clock);
        #1;
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_funct3 = 3'b010;
        cpu_address = 32'h1C4; cpu_writedata = 32'h5555AAAA;
        repeat (3) begin
            @(negedge clock);
            checkOutput("both_busy", cpu_busywait, 0);
            checkOutput("both_mreq", {mem_read, mem_write}, 0);
            checkOutput("both_rdata", cpu_readdata, 0);
        end
        @(posedge clock);
        #1 cpu_read = 1'b0; cpu_write = 1'b0;
        runAccess(1, 0, 3'b010, 32'hC4, 0);

        $display("[TB] random accesses");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] addr;
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0)
                runAccess(1, 0, load_f3[$urandom_range(0, 4)], addr, 0);
            else
                runAccess(0, 1, 3'($urandom_range(0, 2)), addr, $urandom);
        end

        $display("[TB] reset during line fetch");
        @(posedge clock);
        #1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_funct3 = 3'b010; cpu_address = 32'hF40;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clock);
            if (mem_read) seen = 1'b1;
        end
        checkOutput("rst_mr_seen", seen, 1);
        repeat (7) @(negedge clock);
        checkOutput("rst_mr_before", mem_read, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mr_drop", mem_read, 0);
        checkOutput("rst_mw_drop", mem_write, 0);
        checkOutput("rst_mr_busy", cpu_busywait, 0);
        cpu_read = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int b = 0; b < 256; b++)
            for (int k = 0; k < 16; k++) gold[b*16 + k] = back_mem[b][8*k +: 8];
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        runAccess(1, 0, 3'b010, 32'hF40, 0);
        checkOutput("rst_refetch18", obs_busy, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
